// File: rtl/score_display_ctrl.sv
// Two-player BCD score keeper with round-robin increment arbitration, plus a
// per-frame shadowed, two-stage glyph-ROM render pipeline producing score_pixel.
module score_display_ctrl #(
  parameter int X_P0  = 64,
  parameter int X_P1  = 192,
  parameter int Y_TOP = 16,
  parameter int SHIFT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic [1:0] inc_req,
  output logic [1:0] inc_ack,
  input  logic       clr,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic [3:0] rom_digit,
  output logic [2:0] rom_yofs,
  output logic [2:0] rom_xofs,
  input  logic       rom_bits,
  output logic       score_pixel
);

  localparam int FIELD_W = 16 << SHIFT;
  localparam int GLYPH_H = 5 << SHIFT;

  localparam logic [9:0] X0_LO = 10'(X_P0);
  localparam logic [9:0] X0_HI = 10'(X_P0 + FIELD_W);
  localparam logic [9:0] X1_LO = 10'(X_P1);
  localparam logic [9:0] X1_HI = 10'(X_P1 + FIELD_W);
  localparam logic [9:0] Y_LO  = 10'(Y_TOP);
  localparam logic [9:0] Y_HI  = 10'(Y_TOP + GLYPH_H);

  localparam logic [8:0] X0_ORG = 9'(X_P0);
  localparam logic [8:0] X1_ORG = 9'(X_P1);
  localparam logic [8:0] Y_ORG  = 9'(Y_TOP);

  localparam logic [3:0] BLANK_DIGIT = 4'hA;

  // Saturating BCD increment: 99 holds, ones roll 9 -> 0 with carry.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)         return s;
    if (s[3:0] == 4'd9)     return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // ---------------------------------------------------------------------------
  // Score side
  // ---------------------------------------------------------------------------
  logic [7:0] score0_q, score1_q;
  logic [1:0] inc_ack_q;
  logic       last_grant_q;
  logic [1:0] grant_d;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that skips the assignment would otherwise infer a latch.
  always_comb begin
    grant_d = 2'b00;
    if (!clr) begin
      case (inc_req)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
        default: grant_d = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score0_q     <= 8'h00;
      score1_q     <= 8'h00;
      inc_ack_q    <= 2'b00;
      last_grant_q <= 1'b0;
    end else begin
      inc_ack_q <= grant_d;
      if (clr) begin
        score0_q <= 8'h00;
        score1_q <= 8'h00;
      end else begin
        if (grant_d[0]) score0_q <= bcd_inc(score0_q);
        if (grant_d[1]) score1_q <= bcd_inc(score1_q);
      end
      if (grant_d != 2'b00) last_grant_q <= grant_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame shadow: render reads only these, so a score change mid-frame
  // cannot tear the glyphs.
  // ---------------------------------------------------------------------------
  logic [7:0] shadow0_q, shadow1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow0_q <= 8'h00;
      shadow1_q <= 8'h00;
    end else if (hpos == 9'd0 && vpos == 9'd0) begin
      shadow0_q <= score0_q;
      shadow1_q <= score1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: beam position -> ROM address
  // ---------------------------------------------------------------------------
  logic [8:0] dx0, dx1, dy;
  logic [8:0] xo_full, row_full;
  logic       in_x0, in_x1, in_y, sel_p1, ones_sel, hit_d;
  logic [7:0] shadow_sel;
  logic [3:0] digit_sel, digit_d;
  logic [2:0] yofs_d, xofs_d;
  logic       unused_bits;

  always_comb begin
    // Differences wrap in 9 bits; the range checks below gate any wrapped value.
    dx0      = hpos - X0_ORG;
    dx1      = hpos - X1_ORG;
    dy       = vpos - Y_ORG;
    in_x0    = ({1'b0, hpos} >= X0_LO) && ({1'b0, hpos} < X0_HI);
    in_x1    = ({1'b0, hpos} >= X1_LO) && ({1'b0, hpos} < X1_HI);
    in_y     = ({1'b0, vpos} >= Y_LO)  && ({1'b0, vpos} < Y_HI);
    sel_p1   = !in_x0 && in_x1;
    xo_full  = (sel_p1 ? dx1 : dx0) >> SHIFT;
    row_full = dy >> SHIFT;

    shadow_sel = sel_p1 ? shadow1_q : shadow0_q;
    ones_sel   = xo_full[3];
    digit_sel  = ones_sel ? shadow_sel[3:0] : shadow_sel[7:4];

    hit_d = display_on && in_y && (in_x0 || in_x1) && (xo_full[2:0] < 3'd5) &&
            !(!ones_sel && shadow_sel[7:4] == 4'd0);

    digit_d = hit_d ? digit_sel     : BLANK_DIGIT;
    yofs_d  = hit_d ? row_full[2:0] : 3'd0;
    xofs_d  = hit_d ? xo_full[2:0]  : 3'd0;

    unused_bits = ^{xo_full[8:4], row_full[8:3]};
  end

  logic [3:0] rom_digit_q;
  logic [2:0] rom_yofs_q, rom_xofs_q;
  logic       hit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_digit_q <= BLANK_DIGIT;
      rom_yofs_q  <= 3'd0;
      rom_xofs_q  <= 3'd0;
      hit_q       <= 1'b0;
    end else begin
      rom_digit_q <= digit_d;
      rom_yofs_q  <= yofs_d;
      rom_xofs_q  <= xofs_d;
      hit_q       <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: combinational ROM output qualified by the stage-0 hit flag
  // ---------------------------------------------------------------------------
  logic score_pixel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) score_pixel_q <= 1'b0;
    else        score_pixel_q <= rom_bits & hit_q;
  end

  assign inc_ack     = inc_ack_q;
  assign score0      = score0_q;
  assign score1      = score1_q;
  assign rom_digit   = rom_digit_q;
  assign rom_yofs    = rom_yofs_q;
  assign rom_xofs    = rom_xofs_q;
  assign score_pixel = score_pixel_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized bench for score_display_ctrl: decimal score model, frame-shadow
// model and a direct pixel-from-beam model; includes a digits10 ROM stand-in.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on;
  logic [1:0] inc_req;
  logic [1:0] inc_ack;
  logic       clr;
  logic [7:0] score0, score1;
  logic [3:0] rom_digit;
  logic [2:0] rom_yofs, rom_xofs;
  logic       rom_bits;
  logic       score_pixel;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int  m_s[2];
  int  m_sh[2];
  int  m_last;
  bit  m_pipe;
  bit  [1:0] e_ack;
  bit  e_pix;

  score_display_ctrl dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .inc_req(inc_req), .inc_ack(inc_ack), .clr(clr), .score0(score0), .score1(score1),
    .rom_digit(rom_digit), .rom_yofs(rom_yofs), .rom_xofs(rom_xofs),
    .rom_bits(rom_bits), .score_pixel(score_pixel)
  );

  always #5 clk = ~clk;

  // 5x5 glyphs, rows top to bottom, each row written leftmost column first.
  function automatic bit glyph_bit(int d, int r, int c);
    bit [24:0] g;
    case (d)
      0: g = 25'b11111_10001_10001_10001_11111;
      1: g = 25'b01100_00100_00100_00100_11111;
      2: g = 25'b11111_00001_11111_10000_11111;
      3: g = 25'b11111_00001_11111_00001_11111;
      4: g = 25'b10001_10001_11111_00001_00001;
      5: g = 25'b11111_10000_11111_00001_11111;
      6: g = 25'b11111_10000_11111_10001_11111;
      7: g = 25'b11111_00001_00001_00001_00001;
      8: g = 25'b11111_10001_11111_10001_11111;
      9: g = 25'b11111_10001_11111_00001_11111;
      default: return 1'b0;
    endcase
    if (r > 4 || c > 4) return 1'b0;
    return g[24 - (r * 5 + c)];
  endfunction

  always_comb rom_bits = glyph_bit(int'(rom_digit), int'(rom_yofs), int'(rom_xofs));

  function automatic logic [7:0] to_bcd(int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  // Which screen pixel should be lit, straight from field geometry.
  function automatic bit pix_model(int h, int v, bit on, int s0, int s1);
    int base, sc, rel, dsel, col, row, dig;
    if (!on || v < 16 || v >= 36) return 1'b0;
    row = (v - 16) / 4;
    if (h >= 64 && h < 128)        begin base = 64;  sc = s0; end
    else if (h >= 192 && h < 256) begin base = 192; sc = s1; end
    else return 1'b0;
    rel  = (h - base) / 4;
    dsel = rel / 8;
    col  = rel % 8;
    if (col >= 5) return 1'b0;
    dig = (dsel != 0) ? sc % 10 : sc / 10;
    if (dsel == 0 && dig == 0) return 1'b0;
    return glyph_bit(dig, row, col);
  endfunction

  task automatic model_reset();
    m_s[0] = 0; m_s[1] = 0; m_sh[0] = 0; m_sh[1] = 0;
    m_last = 0; m_pipe = 1'b0;
  endtask

  // Predict the effect of the next clock edge from the present inputs, then take it.
  task automatic cycle();
    bit [1:0] g;
    g = 2'b00;
    if (!clr) begin
      if (inc_req == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
      else                  g = inc_req;
    end
    e_pix  = m_pipe;
    m_pipe = pix_model(int'(hpos), int'(vpos), display_on, m_sh[0], m_sh[1]);
    if (hpos == 9'd0 && vpos == 9'd0) begin
      m_sh[0] = m_s[0]; m_sh[1] = m_s[1];
    end
    for (int p = 0; p < 2; p++) begin
      if (clr) m_s[p] = 0;
      else if (g[p] && m_s[p] < 99) m_s[p]++;
    end
    if (g != 2'b00) m_last = g[1] ? 1 : 0;
    e_ack = g;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int v, input int h0, input int h1, input bit on, output int lit);
    lit = 0;
    display_on = on;
    vpos = 9'(v);
    for (int h = h0 - 2; h <= h1 + 2; h++) begin
      hpos = (h < h0 || h > h1) ? 9'd500 : 9'(h);
      cycle();
      if (score_pixel !== e_pix) begin n_err++; $display("FAIL scan_pix v=%0d h=%0d: got %b want %b", v, h, score_pixel, e_pix); end
      n_vec++;
      if (score_pixel === 1'b1) lit++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; hpos = 9'd96; vpos = 9'd16; display_on = 1'b1; inc_req = 2'b00; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    inc_req = 2'b01;
    repeat (3) begin
      cycle();
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL rst_pre_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
      if (score0 !== to_bcd(m_s[0])) begin n_err++; $display("FAIL rst_pre_score0: got %h want %h", score0, to_bcd(m_s[0])); end
      n_vec++;
      if (score_pixel !== e_pix) begin n_err++; $display("FAIL rst_pre_pix: got %b want %b", score_pixel, e_pix); end
      n_vec++;
    end
    // Mid-cycle, with an ack and a lit pixel showing
    #2 reset = 1'b0;
    #1;
    if (inc_ack !== 2'b00) begin n_err++; $display("FAIL rst_ack: got %b want 00", inc_ack); end
    n_vec++;
    if (score0 !== 8'h00 || score1 !== 8'h00) begin n_err++; $display("FAIL rst_scores: got %h/%h want 00/00", score0, score1); end
    n_vec++;
    if (score_pixel !== 1'b0) begin n_err++; $display("FAIL rst_pix: got %b want 0", score_pixel); end
    n_vec++;
    if (rom_digit !== 4'hA) begin n_err++; $display("FAIL rst_rom_digit: got %h want a", rom_digit); end
    n_vec++;
    inc_req = 2'b00; hpos = 9'd5; vpos = 9'd5;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_handshake();
    inc_req = 2'b01;
    repeat (3) begin
      cycle();
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL hs_hold_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
    end
    if (score0 !== 8'h03) begin n_err++; $display("FAIL hs_hold_score0: got %h want 03", score0); end
    n_vec++;
    inc_req = 2'b00;
    cycle();
    for (int r = 0; r < 4; r++) begin
      inc_req = 2'b01;
      cycle();
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL hs_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
      inc_req = inc_req & ~inc_ack;
      repeat ($urandom_range(1, 3)) begin
        cycle();
        if (inc_ack !== e_ack) begin n_err++; $display("FAIL hs_idle_ack: got %b want %b", inc_ack, e_ack); end
        n_vec++;
      end
    end
    if (score0 !== to_bcd(m_s[0])) begin n_err++; $display("FAIL hs_score0: got %h want %h", score0, to_bcd(m_s[0])); end
    n_vec++;
  endtask

  task automatic test_arbitration();
    clr = 1'b1; inc_req = 2'b11;
    cycle();
    clr = 1'b0;
    if (inc_ack !== e_ack) begin n_err++; $display("FAIL arb_clr_ack: got %b want %b", inc_ack, e_ack); end
    n_vec++;
    repeat (4) begin
      cycle();
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL arb_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
    end
    if (score0 !== 8'h02 || score1 !== 8'h02) begin n_err++; $display("FAIL arb_scores: got %h/%h want 02/02", score0, score1); end
    n_vec++;
    // Random held-level requesters that drop on ack
    inc_req = 2'b00;
    repeat (60) begin
      inc_req = inc_req | 2'($urandom_range(0, 3));
      cycle();
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL arb_rand_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
      if (score0 !== to_bcd(m_s[0]) || score1 !== to_bcd(m_s[1])) begin
        n_err++; $display("FAIL arb_rand_scores: got %h/%h want %h/%h", score0, score1, to_bcd(m_s[0]), to_bcd(m_s[1]));
      end
      n_vec++;
      inc_req = inc_req & ~inc_ack;
    end
    inc_req = 2'b00;
  endtask

  task automatic test_bcd();
    clr = 1'b1;
    cycle();
    clr = 1'b0; inc_req = 2'b01;
    for (int i = 1; i <= 100; i++) begin
      cycle();
      if (score0 !== to_bcd(m_s[0])) begin n_err++; $display("FAIL bcd_score0 step %0d: got %h want %h", i, score0, to_bcd(m_s[0])); end
      n_vec++;
      if (i == 9 && score0 !== 8'h09) begin n_err++; $display("FAIL bcd_09: got %h want 09", score0); end
      if (i == 9) n_vec++;
      if (i == 10 && score0 !== 8'h10) begin n_err++; $display("FAIL bcd_10: got %h want 10", score0); end
      if (i == 10) n_vec++;
    end
    if (score0 !== 8'h99 || inc_ack !== 2'b01) begin n_err++; $display("FAIL bcd_sat: got %h ack %b want 99 ack 01", score0, inc_ack); end
    n_vec++;
    clr = 1'b1; inc_req = 2'b11;
    cycle();
    if (inc_ack !== 2'b00 || score0 !== 8'h00 || score1 !== 8'h00) begin
      n_err++; $display("FAIL bcd_clr: got ack %b scores %h/%h want 00 00/00", inc_ack, score0, score1);
    end
    n_vec++;
    clr = 1'b0; inc_req = 2'b00;
  endtask

  task automatic test_render();
    int lit;
    hpos = 9'd5; vpos = 9'd5; display_on = 1'b1;
    inc_req = 2'b01;
    repeat (7) cycle();
    inc_req = 2'b10;
    repeat ($urandom_range(1, 45)) cycle();
    inc_req = 2'b00;
    if (score0 !== 8'h07) begin n_err++; $display("FAIL rnd_setup_score0: got %h want 07", score0); end
    n_vec++;
    hpos = 9'd0; vpos = 9'd0;
    cycle();
    scan(16, 64, 127, 1'b1, lit);
    if (lit != 20) begin n_err++; $display("FAIL rnd_row0_count: got %0d want 20", lit); end
    n_vec++;
    scan(20, 64, 127, 1'b1, lit);
    if (lit != 4) begin n_err++; $display("FAIL rnd_row1_count: got %0d want 4", lit); end
    n_vec++;
    for (int k = 0; k < 3; k++) scan(16 + $urandom_range(0, 19), 192, 255, 1'b1, lit);
    // Free-running random beam and requests
    for (int k = 0; k < 300; k++) begin
      if (k % 60 == 0) begin hpos = 9'd0; vpos = 9'd0; end
      else begin hpos = 9'($urandom_range(0, 300)); vpos = 9'($urandom_range(0, 40)); end
      display_on = ($urandom_range(0, 7) != 0);
      inc_req = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 49) == 0);
      cycle();
      if (score_pixel !== e_pix) begin n_err++; $display("FAIL rnd_pix: got %b want %b", score_pixel, e_pix); end
      n_vec++;
      if (inc_ack !== e_ack) begin n_err++; $display("FAIL rnd_ack: got %b want %b", inc_ack, e_ack); end
      n_vec++;
    end
    clr = 1'b0; inc_req = 2'b00; display_on = 1'b1;
  endtask

  task automatic test_tearing();
    int lit;
    hpos = 9'd5; vpos = 9'd5;
    clr = 1'b1;
    cycle();
    clr = 1'b0; inc_req = 2'b01;
    repeat (7) cycle();
    inc_req = 2'b00;
    hpos = 9'd0; vpos = 9'd0;
    cycle();
    hpos = 9'd5; vpos = 9'd5; inc_req = 2'b01;
    cycle();
    inc_req = 2'b00;
    if (score0 !== 8'h08) begin n_err++; $display("FAIL tear_live: got %h want 08", score0); end
    n_vec++;
    scan(24, 96, 115, 1'b1, lit);
    if (lit != 4) begin n_err++; $display("FAIL tear_old_frame: got %0d want 4", lit); end
    n_vec++;
    hpos = 9'd0; vpos = 9'd0;
    cycle();
    scan(24, 96, 115, 1'b1, lit);
    if (lit != 20) begin n_err++; $display("FAIL tear_new_frame: got %0d want 20", lit); end
    n_vec++;
    scan(16, 64, 255, 1'b0, lit);
    if (lit != 0) begin n_err++; $display("FAIL blank_display_off: got %0d want 0", lit); end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_arbitration();
    test_bcd();
    test_render();
    test_tearing();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
